// File: rtl/pipelined_decoder.sv
`default_nettype none
// ============================================================================
// pipelined_decoder : registered instruction decoder with RAW-hazard scoreboard
// Revision 1.0
// ============================================================================
module pipelined_decoder #(
    parameter int DATA_W     = 32,
    parameter int OPC_W      = 7,
    parameter int RA_W       = 5,
    parameter int IMM_W      = 15,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IR_instruction,
    input  logic              IF_VALID,
    output logic              IF_READY,
    input  logic              EX_READY,
    input  logic              FLUSH,
    output logic              ID_VALID,
    output logic              RW,
    output logic              MW,
    output logic              PS,
    output logic              MA,
    output logic              MB,
    output logic              CS,
    output logic [1:0]        MD,
    output logic [1:0]        BS,
    output logic [4:0]        FS,
    output logic [RA_W-1:0]   DA,
    output logic [RA_W-1:0]   AA,
    output logic [RA_W-1:0]   BA,
    output logic [DATA_W-1:0] IMM,
    output logic              ILLEGAL,
    output logic [15:0]       STALL_CNT
);

    localparam logic [OPC_W-1:0] OP_NOP = 7'b0000000;
    localparam logic [OPC_W-1:0] OP_ST  = 7'b0000001;
    localparam logic [OPC_W-1:0] OP_ADD = 7'b0000010;
    localparam logic [OPC_W-1:0] OP_SUB = 7'b0000101;
    localparam logic [OPC_W-1:0] OP_JML = 7'b0000111;
    localparam logic [OPC_W-1:0] OP_AND = 7'b0001000;
    localparam logic [OPC_W-1:0] OP_OR  = 7'b0001010;
    localparam logic [OPC_W-1:0] OP_XOR = 7'b0001100;
    localparam logic [OPC_W-1:0] OP_BZ  = 7'b0100000;
    localparam logic [OPC_W-1:0] OP_LOD = 7'b0100001;
    localparam logic [OPC_W-1:0] OP_ADI = 7'b0100010;
    localparam logic [OPC_W-1:0] OP_SBI = 7'b0100101;
    localparam logic [OPC_W-1:0] OP_ANI = 7'b0101000;
    localparam logic [OPC_W-1:0] OP_ORI = 7'b0101010;
    localparam logic [OPC_W-1:0] OP_XRI = 7'b0101100;
    localparam logic [OPC_W-1:0] OP_NOT = 7'b0101110;
    localparam logic [OPC_W-1:0] OP_LSL = 7'b0110000;
    localparam logic [OPC_W-1:0] OP_LSR = 7'b0110001;
    localparam logic [OPC_W-1:0] OP_MOV = 7'b1000000;
    localparam logic [OPC_W-1:0] OP_JMP = 7'b1000100;
    localparam logic [OPC_W-1:0] OP_SIU = 7'b1000101;
    localparam logic [OPC_W-1:0] OP_BNZ = 7'b1100000;
    localparam logic [OPC_W-1:0] OP_JMR = 7'b1100001;
    localparam logic [OPC_W-1:0] OP_AIU = 7'b1100010;
    localparam logic [OPC_W-1:0] OP_SLT = 7'b1100101;

    typedef struct packed {
        logic              rw;
        logic              mw;
        logic              ps;
        logic              ma;
        logic              mb;
        logic              cs;
        logic [1:0]        md;
        logic [1:0]        bs;
        logic [4:0]        fs;
        logic [RA_W-1:0]   da;
        logic [RA_W-1:0]   aa;
        logic [RA_W-1:0]   ba;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } ctrl_t;

    logic [OPC_W-1:0] w_opc;
    logic [RA_W-1:0]  w_dr, w_sa, w_sb;
    logic [IMM_W-1:0] w_imm;
    logic             w_use_a, w_use_b, w_known, w_hazard, w_accept;
    ctrl_t            w_dec;

    ctrl_t                          word_q, word_d;
    logic                           id_valid_q, id_valid_d;
    logic [PIPE_DEPTH-1:0]          sb_v_q, sb_v_d;
    logic [PIPE_DEPTH-1:0][RA_W-1:0] sb_da_q, sb_da_d;
    logic [15:0]                    stall_cnt_q, stall_cnt_d;

    assign w_opc = IR_instruction[DATA_W-1 -: OPC_W];
    assign w_dr  = IR_instruction[DATA_W-OPC_W-1 -: RA_W];
    assign w_sa  = IR_instruction[DATA_W-OPC_W-RA_W-1 -: RA_W];
    assign w_sb  = IR_instruction[DATA_W-OPC_W-2*RA_W-1 -: RA_W];
    assign w_imm = IR_instruction[IMM_W-1:0];

    always_comb begin
        w_dec   = '0;
        w_use_a = 1'b0;
        w_use_b = 1'b0;
        w_known = 1'b1;
        case (w_opc)
            OP_NOP: ;
            OP_MOV: w_dec.rw = 1'b1;
            OP_ADD: begin w_dec.rw = 1'b1; w_dec.fs = 5'b00010; w_use_b = 1'b1; end
            OP_SUB: begin w_dec.rw = 1'b1; w_dec.fs = 5'b00101; w_use_b = 1'b1; end
            OP_SLT: begin w_dec.rw = 1'b1; w_dec.fs = 5'b00101; w_dec.md = 2'b10; w_use_b = 1'b1; end
            OP_AND: begin w_dec.rw = 1'b1; w_dec.fs = 5'b01000; w_use_b = 1'b1; end
            OP_OR:  begin w_dec.rw = 1'b1; w_dec.fs = 5'b01010; w_use_b = 1'b1; end
            OP_XOR: begin w_dec.rw = 1'b1; w_dec.fs = 5'b01100; w_use_b = 1'b1; end
            OP_NOT: begin w_dec.rw = 1'b1; w_dec.fs = 5'b01110; end
            OP_LSL: begin w_dec.rw = 1'b1; w_dec.fs = 5'b10000; end
            OP_LSR: begin w_dec.rw = 1'b1; w_dec.fs = 5'b10001; end
            OP_ST:  begin w_dec.mw = 1'b1; w_use_b = 1'b1; end
            OP_LOD: begin w_dec.rw = 1'b1; w_dec.md = 2'b01; end
            OP_ADI: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.cs = 1'b1; w_dec.fs = 5'b00010; end
            OP_SBI: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.cs = 1'b1; w_dec.fs = 5'b00101; end
            OP_ANI: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.fs = 5'b01000; end
            OP_ORI: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.fs = 5'b01010; end
            OP_XRI: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.fs = 5'b01100; end
            OP_AIU: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.fs = 5'b00010; end
            OP_SIU: begin w_dec.rw = 1'b1; w_dec.mb = 1'b1; w_dec.fs = 5'b00101; end
            OP_BZ:  begin w_dec.bs = 2'b01; w_dec.mb = 1'b1; w_dec.cs = 1'b1; end
            OP_BNZ: begin w_dec.bs = 2'b01; w_dec.ps = 1'b1; w_dec.mb = 1'b1; w_dec.cs = 1'b1; end
            OP_JMR: w_dec.bs = 2'b10;
            OP_JMP: begin w_dec.bs = 2'b11; w_dec.mb = 1'b1; w_dec.cs = 1'b1; end
            OP_JML: begin
                w_dec.rw = 1'b1; w_dec.bs = 2'b11; w_dec.mb = 1'b1;
                w_dec.cs = 1'b1; w_dec.ma = 1'b1; w_dec.fs = 5'b00111;
            end
            default: w_known = 1'b0;
        endcase
        // NOP and undefined opcodes keep every field, including IMM, at zero
        if (w_known && (w_opc != OP_NOP)) begin
            w_dec.da = w_dr;
            w_dec.aa = w_sa;
            w_dec.ba = w_sb;
            w_use_a  = (w_opc != OP_JMP);
            w_dec.imm = w_dec.cs ? {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm}
                                 : {{(DATA_W-IMM_W){1'b0}}, w_imm};
        end
        w_dec.illegal = ~w_known;
    end

    always_comb begin
        w_hazard = 1'b0;
        if (id_valid_q && word_q.rw) begin
            if (w_use_a && (w_dec.aa == word_q.da)) w_hazard = 1'b1;
            if (w_use_b && (w_dec.ba == word_q.da)) w_hazard = 1'b1;
        end
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_v_q[i]) begin
                if (w_use_a && (w_dec.aa == sb_da_q[i])) w_hazard = 1'b1;
                if (w_use_b && (w_dec.ba == sb_da_q[i])) w_hazard = 1'b1;
            end
        end
    end

    assign IF_READY = (~id_valid_q | EX_READY) & ~w_hazard & ~FLUSH;
    assign w_accept = IF_VALID & IF_READY;

    always_comb begin
        word_d      = word_q;
        id_valid_d  = id_valid_q;
        sb_v_d      = sb_v_q;
        sb_da_d     = sb_da_q;
        stall_cnt_d = stall_cnt_q;
        if (w_accept) begin
            word_d     = w_dec;
            id_valid_d = 1'b1;
        end else if (EX_READY || FLUSH) begin
            word_d     = '0;
            id_valid_d = 1'b0;
        end
        // The retiring ID/EX entry enters the scoreboard even when flushed
        if (EX_READY) begin
            sb_v_d[0]  = id_valid_q & word_q.rw;
            sb_da_d[0] = word_q.da;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb_v_d[i]  = sb_v_q[i-1];
                sb_da_d[i] = sb_da_q[i-1];
            end
        end
        if (IF_VALID && w_hazard && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            word_q      <= '0;
            id_valid_q  <= 1'b0;
            sb_v_q      <= '0;
            sb_da_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_q      <= word_d;
            id_valid_q  <= id_valid_d;
            sb_v_q      <= sb_v_d;
            sb_da_q     <= sb_da_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ID_VALID  = id_valid_q;
    assign RW        = word_q.rw;
    assign MW        = word_q.mw;
    assign PS        = word_q.ps;
    assign MA        = word_q.ma;
    assign MB        = word_q.mb;
    assign CS        = word_q.cs;
    assign MD        = word_q.md;
    assign BS        = word_q.bs;
    assign FS        = word_q.fs;
    assign DA        = word_q.da;
    assign AA        = word_q.aa;
    assign BA        = word_q.ba;
    assign IMM       = word_q.imm;
    assign ILLEGAL   = word_q.illegal;
    assign STALL_CNT = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decoder.sv
`default_nettype none
// ============================================================================
// tb_pipelined_decoder : directed self-checking bench for pipelined_decoder
// Revision 1.0
// ============================================================================
module tb_pipelined_decoder;

    localparam logic [6:0] OP_ST  = 7'b0000001;
    localparam logic [6:0] OP_ADD = 7'b0000010;
    localparam logic [6:0] OP_SUB = 7'b0000101;
    localparam logic [6:0] OP_AND = 7'b0001000;
    localparam logic [6:0] OP_OR  = 7'b0001010;
    localparam logic [6:0] OP_LOD = 7'b0100001;
    localparam logic [6:0] OP_ADI = 7'b0100010;
    localparam logic [6:0] OP_JMP = 7'b1000100;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        CLK = 1'b0;
    logic        RESET, IF_VALID, EX_READY, FLUSH;
    logic [31:0] IR_instruction;
    logic        IF_READY, ID_VALID, RW, MW, PS, MA, MB, CS, ILLEGAL;
    logic [1:0]  MD, BS;
    logic [4:0]  FS, DA, AA, BA;
    logic [31:0] IMM;
    logic [15:0] STALL_CNT;

    int tests = 0;
    int fails = 0;
    int stalls, bubbles;

    always #5 CLK = ~CLK;

    pipelined_decoder #(
        .DATA_W(32), .OPC_W(7), .RA_W(5), .IMM_W(15), .PIPE_DEPTH(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .IR_instruction(IR_instruction),
        .IF_VALID(IF_VALID), .IF_READY(IF_READY), .EX_READY(EX_READY),
        .FLUSH(FLUSH), .ID_VALID(ID_VALID), .RW(RW), .MW(MW), .PS(PS),
        .MA(MA), .MB(MB), .CS(CS), .MD(MD), .BS(BS), .FS(FS), .DA(DA),
        .AA(AA), .BA(BA), .IMM(IMM), .ILLEGAL(ILLEGAL), .STALL_CNT(STALL_CNT)
    );

    function automatic logic [31:0] ins(input logic [6:0] op, input logic [4:0] dr,
                                        input logic [4:0] sa, input logic [4:0] sb);
        return {op, dr, sa, sb, 10'd0};
    endfunction

    function automatic logic [31:0] insi(input logic [6:0] op, input logic [4:0] dr,
                                         input logic [4:0] sa, input logic [14:0] imm);
        return {op, dr, sa, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        IF_VALID = 1'b0;
        EX_READY = 1'b1;
        FLUSH    = 1'b0;
        repeat (4) tick();
    endtask

    // Counts cycles with IF_READY low and bubbles issued meanwhile; bounded.
    task automatic stall_loop(output int n_stall, output int n_bub);
        n_stall = 0;
        n_bub   = 0;
        #1;
        while (IF_READY !== 1'b1 && n_stall < 10) begin
            n_stall++;
            tick();
            if (ID_VALID === 1'b0) n_bub++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; IF_VALID = 1'b0; EX_READY = 1'b1; FLUSH = 1'b0;
        IR_instruction = 32'd0;
        repeat (2) tick();
        RESET = 1'b0;
        #1;
        chk("rst_id_valid", ID_VALID, 0);
        chk("rst_rw", RW, 0);
        chk("rst_fs", FS, 0);
        chk("rst_da", DA, 0);
        chk("rst_imm", IMM, 0);
        chk("rst_illegal", ILLEGAL, 0);
        chk("rst_stall_cnt", STALL_CNT, 0);
        chk("rst_if_ready", IF_READY, 1);

        // ADD, ADI, LOD back to back
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        IF_VALID = 1'b1;
        tick();
        chk("add_valid", ID_VALID, 1);
        chk("add_rw", RW, 1);
        chk("add_fs", FS, 5'b00010);
        chk("add_mb", MB, 0);
        chk("add_da", DA, 3);
        chk("add_aa", AA, 1);
        chk("add_ba", BA, 2);
        IR_instruction = insi(OP_ADI, 5'd4, 5'd5, 15'h7FFF);
        #1;
        chk("adi_ready", IF_READY, 1);
        tick();
        chk("adi_mb", MB, 1);
        chk("adi_cs", CS, 1);
        chk("adi_imm", IMM, 32'hFFFF_FFFF);
        chk("adi_da", DA, 4);
        chk("adi_fs", FS, 5'b00010);
        IR_instruction = ins(OP_LOD, 5'd8, 5'd9, 5'd0);
        tick();
        chk("lod_md", MD, 2'b01);
        chk("lod_rw", RW, 1);
        chk("lod_cs", CS, 0);
        chk("lod_aa", AA, 9);
        drain();
        chk("drain_valid", ID_VALID, 0);

        // Back-to-back RAW: ADD R3 then SUB R6,R3,R7
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        IF_VALID = 1'b1;
        tick();
        IR_instruction = ins(OP_SUB, 5'd6, 5'd3, 5'd7);
        stall_loop(stalls, bubbles);
        chk("raw_stall_cycles", stalls, 3);
        chk("raw_bubbles", bubbles, 3);
        tick();
        chk("sub_valid", ID_VALID, 1);
        chk("sub_fs", FS, 5'b00101);
        chk("sub_da", DA, 6);
        chk("raw_stall_cnt", STALL_CNT, 3);
        drain();

        // ST reading R3 via B stalls
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        IF_VALID = 1'b1;
        tick();
        IR_instruction = ins(OP_ST, 5'd0, 5'd1, 5'd3);
        stall_loop(stalls, bubbles);
        chk("st_stall_cycles", stalls, 3);
        tick();
        chk("st_mw", MW, 1);
        chk("st_rw", RW, 0);
        chk("st_stall_cnt", STALL_CNT, 6);
        // JMP with R3 in the B field does not stall
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        tick();
        IR_instruction = ins(OP_JMP, 5'd0, 5'd0, 5'd3);
        #1;
        chk("jmp_ready", IF_READY, 1);
        tick();
        chk("jmp_bs", BS, 2'b11);
        chk("jmp_mb", MB, 1);
        chk("jmp_imm", IMM, 32'h0000_0C00);
        drain();

        // EX_READY low holds ID/EX; FLUSH then clears it but not the scoreboard
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        IF_VALID = 1'b1;
        tick();
        IR_instruction = ins(OP_AND, 5'd5, 5'd1, 5'd2);
        tick();
        EX_READY = 1'b0;
        IR_instruction = ins(OP_OR, 5'd7, 5'd1, 5'd2);
        #1;
        chk("hold_ready0", IF_READY, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_valid", ID_VALID, 1);
            chk("hold_da", DA, 5);
            chk("hold_fs", FS, 5'b01000);
            chk("hold_ready", IF_READY, 0);
        end
        IF_VALID = 1'b0;
        FLUSH = 1'b1;
        tick();
        chk("flush_valid", ID_VALID, 0);
        chk("flush_rw", RW, 0);
        chk("flush_da", DA, 0);
        FLUSH = 1'b0;
        IF_VALID = 1'b1;
        IR_instruction = ins(OP_SUB, 5'd6, 5'd3, 5'd7);
        #1;
        chk("flush_sb_kept", IF_READY, 0);
        IR_instruction = ins(OP_OR, 5'd7, 5'd1, 5'd2);
        #1;
        chk("flush_nohaz_ready", IF_READY, 1);
        drain();

        // Undefined opcode whose fields alias an in-flight destination
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        IF_VALID = 1'b1;
        tick();
        IR_instruction = ins(OP_BAD, 5'd9, 5'd3, 5'd3);
        #1;
        chk("ill_ready", IF_READY, 1);
        tick();
        chk("ill_valid", ID_VALID, 1);
        chk("ill_flag", ILLEGAL, 1);
        chk("ill_rw", RW, 0);
        chk("ill_mw", MW, 0);
        chk("ill_bs", BS, 0);
        chk("ill_da", DA, 0);
        chk("ill_aa", AA, 0);
        chk("ill_ba", BA, 0);
        IF_VALID = 1'b0;
        tick();
        chk("ill_clear", ILLEGAL, 0);
        drain();
        chk("total_stall_cnt", STALL_CNT, 6);

        // Reset in the middle of a stall
        IR_instruction = ins(OP_ADD, 5'd3, 5'd1, 5'd2);
        IF_VALID = 1'b1;
        tick();
        IR_instruction = ins(OP_SUB, 5'd6, 5'd3, 5'd7);
        #1;
        chk("rs_stalled", IF_READY, 0);
        tick();
        chk("rs_cnt_pre", STALL_CNT, 7);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        chk("rs_valid", ID_VALID, 0);
        chk("rs_cnt", STALL_CNT, 0);
        chk("rs_ready", IF_READY, 1);
        IF_VALID = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
